// File: rtl/lock_pkg.sv
// Shared definitions for the six-digit lock: key codes, digit count and
// the entry state encoding used by the keypad-side collector.
package lock_pkg;

    localparam logic [3:0] KEY_BKSP   = 4'hA;
    localparam logic [3:0] KEY_CLR    = 4'hB;
    localparam logic [3:0] KEY_ENT    = 4'hC;
    localparam int         NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        CHECK = 2'd2
    } state_t;

    // True for the BCD digit keys 0..9.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Generic terminal-count down-counter. load presets MAX_COUNT, en counts
// down to zero and holds there; expired flags the last counted cycle
// (count == 1) so the owner can act on the edge that would reach zero.
module entry_timer #(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int         W        = $clog2(MAX_COUNT + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(MAX_COUNT);

    logic [W-1:0] count_r;

    // Counter: clear/reset to zero, preload, or saturating count-down.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (en && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == W'(1));

endmodule

// File: rtl/code_entry.sv
// Keypad digit collector for the six-digit lock. Keys are registered once,
// then applied to the digit store on the following edge, so every output is
// a register. Optional idle timeout: define CODE_ENTRY_TIMEOUT_EN.
module code_entry
    import lock_pkg::*;
#(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic [3:0] a3,
    output logic [3:0] a4,
    output logic [3:0] a5,
    output logic [3:0] a6,
    output logic       s,
    output logic [2:0] digit_cnt,
    output logic       busy,
    output logic       err,
    output logic       timeout
);

    localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_r;
    logic [3:0] digits_r [NUM_DIGITS];
    logic [2:0] digit_cnt_r;
    logic       key_valid_r;
    logic [3:0] key_code_r;
    logic       s_r;
    logic       err_r;
    logic       busy_r;
    logic       timeout_r;
    logic       hold_load_s;
    logic       hold_expired_s;
    logic       idle_fire_s;

    // A confirmed enter on a full entry starts the freeze window.
    assign hold_load_s = key_valid_r && (key_code_r == KEY_ENT) &&
                         (state_r != CHECK) && (digit_cnt_r == FULL_CNT);

    entry_timer #(.MAX_COUNT(HOLD_CYCLES)) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .load    (hold_load_s),
        .en      (state_r == CHECK),
        .expired (hold_expired_s)
    );

`ifdef CODE_ENTRY_TIMEOUT_EN
    logic idle_expired_s;

    entry_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .load    (key_valid),
        .en      (1'b1),
        .expired (idle_expired_s)
    );

    // A key in flight always beats an expiring idle count.
    assign idle_fire_s = idle_expired_s && (state_r == ENTRY) &&
                         !key_valid && !key_valid_r;
`else
    assign idle_fire_s = 1'b0;
`endif

    // Entry FSM: key register, digit store, counters and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            digit_cnt_r <= 3'd0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'h0;
            s_r         <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
        end else begin
            key_valid_r <= key_valid;
            key_code_r  <= key_code;
            s_r         <= 1'b0;
            err_r       <= 1'b0;
            timeout_r   <= 1'b0;
            case (state_r)
                CHECK: begin
                    if (hold_expired_s) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        digit_cnt_r <= 3'd0;
                        for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
                    end else begin
                        state_r <= CHECK;
                    end
                end
                IDLE, ENTRY: begin
                    if (key_valid_r) begin
                        if (is_digit(key_code_r)) begin
                            if (digit_cnt_r < FULL_CNT) begin
                                digits_r[digit_cnt_r] <= key_code_r;
                                digit_cnt_r           <= digit_cnt_r + 3'd1;
                                state_r               <= ENTRY;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else begin
                            case (key_code_r)
                                KEY_BKSP: begin
                                    if (digit_cnt_r == 3'd0) begin
                                        err_r <= 1'b1;
                                    end else begin
                                        digits_r[digit_cnt_r - 3'd1] <= 4'h0;
                                        digit_cnt_r <= digit_cnt_r - 3'd1;
                                        state_r     <= (digit_cnt_r == 3'd1) ? IDLE : ENTRY;
                                    end
                                end
                                KEY_CLR: begin
                                    state_r     <= IDLE;
                                    digit_cnt_r <= 3'd0;
                                    for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
                                end
                                KEY_ENT: begin
                                    if (digit_cnt_r == FULL_CNT) begin
                                        state_r <= CHECK;
                                        busy_r  <= 1'b1;
                                        s_r     <= 1'b1;
                                    end else begin
                                        err_r       <= 1'b1;
                                        state_r     <= IDLE;
                                        digit_cnt_r <= 3'd0;
                                        for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
                                    end
                                end
                                default: begin
                                    state_r <= state_r;
                                end
                            endcase
                        end
                    end else if (idle_fire_s) begin
                        timeout_r   <= 1'b1;
                        state_r     <= IDLE;
                        digit_cnt_r <= 3'd0;
                        for (int i = 0; i < NUM_DIGITS; i++) digits_r[i] <= 4'h0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign a1        = digits_r[0];
    assign a2        = digits_r[1];
    assign a3        = digits_r[2];
    assign a4        = digits_r[3];
    assign a5        = digits_r[4];
    assign a6        = digits_r[5];
    assign digit_cnt = digit_cnt_r;
    assign s         = s_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed test-plan sequences plus
// randomized keys, all compared every cycle against a queue-based model.
module tb_code_entry;

    localparam int HOLD = 4;
    localparam int TMO  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] a1, a2, a3, a4, a5, a6;
    logic       s, busy, err, timeout;
    logic [2:0] digit_cnt;

    code_entry #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .a4        (a4),
        .a5        (a5),
        .a6        (a6),
        .s         (s),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .err       (err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entered digits as a queue, a freeze countdown, a
    // one-cycle key latency and a run length of key-free cycles.
    int         m_q[$];
    bit         m_check;
    int         m_hold_left;
    bit         m_s, m_err, m_to;
    bit         pend_v;
    logic [3:0] pend_c;
    int         idle_run;

    // Event tallies for the directed test-plan checks.
    int         s_count, busy_count, err_count, to_count;
    logic [23:0] s_digits;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] m_packed();
        logic [23:0] r = 24'h0;
        for (int i = 0; i < 6; i++) begin
            r = {r[19:0], (i < m_q.size()) ? 4'(m_q[i]) : 4'h0};
        end
        return r;
    endfunction

    task automatic m_apply(input logic [3:0] c);
        if (c <= 4'd9) begin
            if (m_q.size() < 6) m_q.push_back(int'(c));
            else m_err = 1;
        end else if (c == 4'hA) begin
            if (m_q.size() == 0) m_err = 1;
            else void'(m_q.pop_back());
        end else if (c == 4'hB) begin
            m_q.delete();
        end else if (c == 4'hC) begin
            if (m_q.size() == 6) begin
                m_check = 1; m_hold_left = HOLD; m_s = 1;
            end else begin
                m_err = 1; m_q.delete();
            end
        end
    endtask

    task automatic m_edge(input bit r, input bit kv, input logic [3:0] kc);
        if (r) begin
            m_q.delete(); m_check = 0; m_hold_left = 0;
            m_s = 0; m_err = 0; m_to = 0; pend_v = 0; pend_c = 4'h0; idle_run = 0;
            return;
        end
        m_s = 0; m_err = 0; m_to = 0;
        if (kv) idle_run = 0;
        else idle_run++;
        if (m_check) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_check = 0; m_q.delete();
            end
        end else if (pend_v) begin
            m_apply(pend_c);
        end
`ifdef CODE_ENTRY_TIMEOUT_EN
        else if (m_q.size() > 0 && idle_run == TMO) begin
            m_q.delete(); m_to = 1;
        end
`endif
        pend_v = kv;
        pend_c = kc;
    endtask

    task automatic step(input bit r, input bit kv, input logic [3:0] kc);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc;
        @(posedge clk);
        m_edge(r, kv, kc);
        #1;
        check_eq("digits",    {a1, a2, a3, a4, a5, a6}, m_packed());
        check_eq("digit_cnt", digit_cnt, m_q.size());
        check_eq("s",         s,       m_s);
        check_eq("busy",      busy,    m_check);
        check_eq("err",       err,     m_err);
        check_eq("timeout",   timeout, m_to);
        if (s) begin s_count++; s_digits = {a1, a2, a3, a4, a5, a6}; end
        if (busy) busy_count++;
        if (err) err_count++;
        if (timeout) to_count++;
    endtask

    task automatic key(input logic [3:0] c);
        step(1'b0, 1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic clear_tally();
        s_count = 0; busy_count = 0; err_count = 0; to_count = 0; s_digits = 24'h0;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        clear_tally();
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        check_eq("reset_cnt", digit_cnt, 32'd0);
        check_eq("reset_busy", busy, 32'd0);

        // Full entry and confirm.
        clear_tally();
        for (int d = 1; d <= 6; d++) key(4'(d));
        key(4'hC);
        idle(7);
        check_eq("tp1_s_count", s_count, 32'd1);
        check_eq("tp1_digits", s_digits, 32'h123456);
        check_eq("tp1_busy_cycles", busy_count, 32'd4);
        check_eq("tp1_final_cnt", digit_cnt, 32'd0);

        // Backspace handling.
        clear_tally();
        key(4'd7); key(4'd8); key(4'hA); key(4'd9);
        idle(1);
        check_eq("tp2_digits", {a1, a2, a3, a4, a5, a6}, 32'h790000);
        check_eq("tp2_cnt", digit_cnt, 32'd2);
        key(4'hA); key(4'hA); key(4'hA);
        idle(1);
        check_eq("tp2_cnt0", digit_cnt, 32'd0);
        check_eq("tp2_err", err_count, 32'd1);

        // Overflow digit, then enter during CHECK.
        clear_tally();
        for (int d = 1; d <= 6; d++) key(4'(d));
        key(4'd5);
        idle(1);
        check_eq("tp3_digits", {a1, a2, a3, a4, a5, a6}, 32'h123456);
        check_eq("tp3_err", err_count, 32'd1);
        key(4'hC); idle(1); key(4'hC);
        idle(6);
        check_eq("tp3_err_after", err_count, 32'd1);
        check_eq("tp3_s_count", s_count, 32'd1);

        // Short enter.
        clear_tally();
        key(4'd1); key(4'd2); key(4'd3); key(4'hC);
        idle(2);
        check_eq("tp4_err", err_count, 32'd1);
        check_eq("tp4_s", s_count, 32'd0);
        check_eq("tp4_cnt", digit_cnt, 32'd0);

        // Idle timeout.
        clear_tally();
        key(4'd3);
        idle(TMO + 2);
`ifdef CODE_ENTRY_TIMEOUT_EN
        check_eq("tp5_timeout", to_count, 32'd1);
        check_eq("tp5_cnt", digit_cnt, 32'd0);
`else
        check_eq("tp5_timeout", to_count, 32'd0);
        check_eq("tp5_cnt", digit_cnt, 32'd1);
`endif
        key(4'hB);
        idle(1);

        // Reset during CHECK, then a normal entry.
        clear_tally();
        for (int d = 1; d <= 6; d++) key(4'(d));
        key(4'hC);
        idle(2);
        step(1'b1, 1'b0, 4'h0);
        check_eq("tp6_rst_cnt", digit_cnt, 32'd0);
        check_eq("tp6_rst_busy", busy, 32'd0);
        check_eq("tp6_rst_digits", {a1, a2, a3, a4, a5, a6}, 32'h0);
        clear_tally();
        for (int d = 1; d <= 6; d++) key(4'(d));
        key(4'hC);
        idle(6);
        check_eq("tp6_s_count", s_count, 32'd1);
        check_eq("tp6_digits", s_digits, 32'h123456);

        // Randomized keys with occasional resets and idle stretches.
        for (int i = 0; i < 3000; i++) begin
            bit         r  = ($urandom_range(0, 299) == 0);
            bit         kv = ($urandom_range(0, 99) < 45);
            logic [3:0] kc = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9))
                                                         : 4'($urandom_range(10, 15));
            step(r, kv, kc);
            if ($urandom_range(0, 149) == 0) idle(TMO + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/code_entry.md
# code_entry

Keypad-side digit collector for the six-digit lock. It accepts one 4-bit key code per valid cycle and assembles up to six BCD digits into registers a1..a6. On a complete, confirmed entry it presents those digits, stable, to the downstream code comparator and issues a one-cycle compare strobe. The comparator matches a1..a6 against the stored b1..b6 and produces the match flag.

## Interface
- HOLD_CYCLES, 4: cycles a1..a6 stay frozen after the compare strobe before auto-clear; legal range is 1 or more.
- TIMEOUT_CYCLES, 50_000_000: idle cycles in ENTRY before the partial entry is discarded (used only with the timeout feature).
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- key_valid  in  1  one-cycle qualifier for key_code.
- key_code  in  4  0–9 digit; 4'hA backspace; 4'hB clear; 4'hC enter; 4'hD–4'hF ignored.
- a1..a6  out  4 each  entered digits; a1 is the first digit entered, unfilled positions are 4'h0.
- s  out  1  compare strobe to the comparator; one-cycle pulse.
- digit_cnt  out  3  number of digits held, 0–6.
- busy  out  1  high in CHECK; keys are ignored while high.
- err  out  1  one-cycle pulse on a rejected operation.
- timeout  out  1  one-cycle pulse when an entry times out; tied to 0 when the feature is compiled out.

## Operation
- States: IDLE (digit_cnt=0), ENTRY (1..6 digits), CHECK (frozen, awaiting auto-clear).
- Digit in IDLE/ENTRY with digit_cnt<6: write to position digit_cnt+1, increment; IDLE→ENTRY.
- Digit with digit_cnt=6: ignored, err pulse, no state change.
- Backspace: zero position digit_cnt, decrement; at 1→0 go to IDLE. Backspace in IDLE: err pulse only.
- Clear: zero all six, digit_cnt=0, go to IDLE; no err, even in IDLE.
- Enter with digit_cnt=6: go to CHECK and pulse s in the cycle following the key. Digits are not modified.
- Enter with digit_cnt<6: err pulse, clear all digits, go to IDLE.
- Codes D–F: no effect.
- CHECK: all keys ignored with no err. The hold counter runs HOLD_CYCLES, then digits zero, digit_cnt=0, go to IDLE.
- Only one key action per cycle. Outputs change only on key_valid cycles or on counter expiry.

## Timing
- Reset values: a1..a6=0, digit_cnt=0, s=0, busy=0, err=0, timeout=0; state IDLE; all counters 0.
- Key accepted at edge N: digits, digit_cnt and state are updated at edge N+1; err/s are high for the cycle after N+1 only.
- s rises the same cycle busy rises; a1..a6 are guaranteed stable from that cycle through the last CHECK cycle.
- CHECK lasts exactly HOLD_CYCLES cycles; busy falls and digits clear on the same edge.
- rst mid-entry or mid-CHECK: immediate return to reset values at the next edge; no s or err emitted.
- The hold counter and timeout counter are sized $clog2(param+1); no wrap is possible because each saturates or clears at its terminal value.

## Configuration
- CODE_ENTRY_TIMEOUT_EN defined: an idle counter runs in ENTRY and resets on every key_valid. On reaching TIMEOUT_CYCLES it clears the digits, goes to IDLE and pulses timeout for one cycle. Expiry in the same cycle as a key_valid: the key wins and the counter resets.
- Not defined: there is no idle counter, the timeout output is constant 0, and a partial entry persists indefinitely.

## Structure
- Shared package lock_pkg: key-code constants (KEY_BKSP=4'hA, KEY_CLR=4'hB, KEY_ENT=4'hC), NUM_DIGITS=6, and the state enum {IDLE, ENTRY, CHECK}.
- One sub-module, entry_timer: a generic terminal-count down-counter with load/clear, instantiated for the hold count and, under the macro, for the timeout count.

## Test plan
- Keys 1,2,3,4,5,6 then enter → a1..a6=1..6, digit_cnt=6, s pulses once one cycle after enter, busy high 4 cycles, then all zero and IDLE.
- Keys 7,8,backspace,9 → a1=7, a2=9, digit_cnt=2; backspace ×3 → digit_cnt=0, one err pulse on the third backspace.
- Six digits then digit 5 → digits unchanged, one err pulse; enter during CHECK → ignored, no err.
- Keys 1,2,3 then enter → err pulse, no s, digits cleared, IDLE.
- With the macro defined, TIMEOUT_CYCLES=10: key 3 then 10 idle cycles → timeout pulse, digit_cnt=0; the same sequence without the macro → digit_cnt stays 1.
- rst asserted during CHECK cycle 2 → next edge all outputs at reset values; a following 1–6+enter sequence behaves normally.
